// File: rtl/pc_trace_monitor_pkg.sv
// pc_trace_monitor_pkg: shared state encoding and well-known fetch vectors for the PC trace monitor
package pc_trace_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam int          SUP_BIT   = 31;
endpackage

// File: rtl/pc_trace_monitor_if.sv
// pc_trace_monitor_if: fetch stream, trace load port and result bus of the PC trace monitor
interface pc_trace_monitor_if #(parameter int AW = 10, parameter int DW = 32);
  logic [DW-1:0] InstAdd;
  logic          exp_wr_en;
  logic [AW-1:0] exp_wr_addr;
  logic [DW-1:0] exp_wr_data;
  logic [AW:0]   trace_len;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   mismatch_count;
  logic          first_err_valid;
  logic [AW-1:0] first_err_idx;
  logic [DW-1:0] first_err_addr;
  logic [DW-1:0] first_err_exp;
  modport master (output InstAdd, exp_wr_en, exp_wr_addr, exp_wr_data, trace_len, start,
                  input busy, done, pass, mismatch_count, first_err_valid, first_err_idx,
                  first_err_addr, first_err_exp);
  modport slave  (input InstAdd, exp_wr_en, exp_wr_addr, exp_wr_data, trace_len, start,
                  output busy, done, pass, mismatch_count, first_err_valid, first_err_idx,
                  first_err_addr, first_err_exp);
endinterface

// File: rtl/pc_trace_ram.sv
// pc_trace_ram: expected-trace storage, synchronous write and asynchronous read
module pc_trace_ram #(parameter int DEPTH = 1024, parameter int AW = 10, parameter int DW = 32) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: checks InstAdd against a preloaded PC trace; STOP_ON_FAIL_EN ends the run at the first mismatch
module pc_trace_monitor import pc_trace_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             RESET,
  pc_trace_monitor_if.slave bus
);
  state_t        state;
  logic [AW:0]   len;
  logic [AW-1:0] idx;
  logic [AW:0]   cnt;
  logic          fe_valid;
  logic [AW-1:0] fe_idx;
  logic [DW-1:0] fe_addr;
  logic [DW-1:0] fe_exp;
  logic [DW-1:0] rdata;
  logic          mis;
  logic          last;
  pc_trace_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .we   (bus.exp_wr_en && state == IDLE),
    .waddr(bus.exp_wr_addr),
    .wdata(bus.exp_wr_data),
    .raddr(idx),
    .rdata(rdata)
  );
  assign mis  = bus.InstAdd != rdata;
  assign last = {1'b0, idx} == len - 1'b1;
  always_ff @(posedge clk)
    if (RESET) begin
      state    <= IDLE;
      len      <= '0;
      idx      <= '0;
      cnt      <= '0;
      fe_valid <= 1'b0;
      fe_idx   <= '0;
      fe_addr  <= '0;
      fe_exp   <= '0;
    end else if (state != RUN) begin
      if (bus.start) begin
        state    <= bus.trace_len == '0 ? DONE : RUN;
        len      <= bus.trace_len;
        idx      <= '0;
        cnt      <= '0;
        fe_valid <= 1'b0;
        fe_idx   <= '0;
        fe_addr  <= '0;
        fe_exp   <= '0;
      end
    end else begin
      idx <= idx + 1'b1;
      if (mis) begin
        cnt <= &cnt ? cnt : cnt + 1'b1;
        if (!fe_valid) begin
          fe_valid <= 1'b1;
          fe_idx   <= idx;
          fe_addr  <= bus.InstAdd;
          fe_exp   <= rdata;
        end
      end
`ifdef STOP_ON_FAIL_EN
      if (mis) state <= FAIL;
      else if (last) state <= cnt == '0 ? DONE : FAIL;
`else
      if (last) state <= (cnt == '0 && !mis) ? DONE : FAIL;
`endif
    end
  assign bus.busy            = state == RUN;
  assign bus.done            = state == DONE || state == FAIL;
  assign bus.pass            = state == DONE && cnt == '0;
  assign bus.mismatch_count  = cnt;
  assign bus.first_err_valid = fe_valid;
  assign bus.first_err_idx   = fe_idx;
  assign bus.first_err_addr  = fe_addr;
  assign bus.first_err_exp   = fe_exp;
endmodule
